regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the single access port of the 16x8 register file between two requesters: the CPU control unit (CPU) and the debug/loader port (DBG).
- Sits between both requesters and the register file.
- Per-requester req/gnt handshake; round-robin arbitration; read data returned one cycle after the grant.
- Guarantees that no register-file write strobe is issued unless exactly one requester holds the grant.

Parameters:
- DATA_W, 8, register width.
- ADDR_W, 4, register index width (16 registers).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt is seen
- cpu_rw  in  1  1 = write, 0 = read
- cpu_reg  in  ADDR_W  register index
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  one-cycle grant pulse
- cpu_rvalid  out  1  read data valid for CPU
- dbg_req, dbg_rw, dbg_reg, dbg_wdata  in  1/1/ADDR_W/DATA_W  same meaning, DBG side
- dbg_gnt, dbg_rvalid  out  1/1  same meaning, DBG side
- rdata  out  DATA_W  shared read data (= rf_out); qualified by the *_rvalid signals
- rf_regname  out  ADDR_W  register file index
- rf_rw  out  1  register file write enable
- rf_in  out  DATA_W  register file write data
- rf_out  in  DATA_W  register file read data; valid the cycle after index is presented

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, all gnt/rvalid=0, rf_rw=0, rf_regname=0, rf_in=0.
  - RR pointer favours CPU.
  - Takes effect immediately, also mid-GRANT: an in-flight write is aborted and rf_rw drops without waiting for clk.
- FSM states: IDLE, GRANT, RESP.
- IDLE:
  - On each edge, sample cpu_req/dbg_req.
  - If any request is high: select a winner, register its rw/reg/wdata onto rf_*, set the winner's gnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (exactly 1 cycle):
  - Winner's gnt=1; rf_regname/rf_in hold the captured command; rf_rw=captured rw.
  - The register file commits the write or latches read data on the edge ending GRANT.
  - Always go to RESP.
- RESP (exactly 1 cycle):
  - rf_rw=0; gnt=0.
  - If the served access was a read, the served requester's rvalid=1 and rdata=rf_out (requested register).
  - At the end of RESP, arbitrate as in IDLE: go to GRANT if any req is high, else IDLE.
  - Peak throughput: one access per 2 cycles.
- Handshake:
  - Requester holds req and its fields stable until it sees gnt=1.
  - Requester deasserts req (or presents a new command) in the cycle after gnt.
  - A req that drops before gnt is a legal withdrawal; no access is made.
  - Fields are captured only at the arbitration edge.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the one not granted last wins. After reset, CPU wins the first tie.
  - Pointer updates only on grant.
- Latency: req high at edge E (in IDLE) -> gnt in cycle E+1 -> rvalid in cycle E+2.
- Outputs outside GRANT: rf_rw=0; rf_regname/rf_in hold their last value. No spurious writes.
- Simultaneous read and write to the same register by different requesters: serialized in grant order. A read granted after a write returns the new value.
- Never both gnt=1 or both rvalid=1 in the same cycle.

Optional Feature:
- Macro: REGFILE_ARB_LOCK_EN.
- When defined:
  - Extra input dbg_lock (1 bit).
  - While dbg_lock=1 and the last grant went to DBG, CPU requests are not granted; CPU waits and its req stays pending.
  - This gives DBG atomic read-modify-write sequences.
  - Lock is ignored when DBG does not own the last grant.
  - Reset clears lock ownership.
- When undefined: port absent; pure round-robin.

Test Plan:
- Reset: hold rst_n=0 with both reqs high -> all gnt/rvalid/rf_rw = 0. Release -> first grant goes to CPU.
- CPU write: cpu_req=1, rw=1, reg=3, wdata=0x5A -> cpu_gnt in next cycle with rf_rw=1, rf_regname=3, rf_in=0x5A. No rvalid. Then a CPU read of reg 3 returns rdata=0x5A with cpu_rvalid exactly 2 cycles after req sampled.
- Contention: both reqs held continuously -> grants alternate CPU, DBG, CPU, DBG on every GRANT state (every 2 cycles); never both in the same cycle.
- Ordering: DBG writes R5=0x11 and CPU reads R5 in the same cycle, with DBG last-winner=CPU -> DBG granted first; CPU then reads 0x11.
- Reset mid-operation: assert rst_n=0 during a GRANT carrying a write of 0xFF to R2 -> rf_rw drops asynchronously; R2 unchanged; FSM restarts in IDLE.
- With REGFILE_ARB_LOCK_EN: DBG reads R1 with dbg_lock=1 and cpu_req held -> cpu_gnt stays 0 while DBG writes R1. After dbg_lock=0 -> CPU granted on the next arbitration.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the 16x8 register-file port between CPU and DBG requesters.
// Optional define REGFILE_ARB_LOCK_EN adds dbg_lock so DBG can hold off the CPU between its own accesses.
module regfile_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_reg,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_rw,
  input  logic [ADDR_W-1:0] dbg_reg,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic              dbg_lock,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rf_regname,
  output logic              rf_rw,
  output logic [DATA_W-1:0] rf_in,
  input  logic [DATA_W-1:0] rf_out
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_e;

  state_e            state_q, state_d;
  logic              sel_dbg_q, sel_dbg_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              last_cpu_q, last_cpu_d;
  logic              last_dbg_q, last_dbg_d;
  logic              cpu_ok;
  logic              win_dbg;

  // Both "last" flags clear on reset: no owner for the lock, and CPU wins the first tie.
`ifdef REGFILE_ARB_LOCK_EN
  assign cpu_ok = cpu_req && !(dbg_lock && last_dbg_q);
`else
  assign cpu_ok = cpu_req;
`endif
  assign win_dbg = dbg_req && (!cpu_ok || last_cpu_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_dbg_q  <= 1'b0;
      rw_q       <= 1'b0;
      reg_q      <= '0;
      in_q       <= '0;
      last_cpu_q <= 1'b0;
      last_dbg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_dbg_q  <= sel_dbg_d;
      rw_q       <= rw_d;
      reg_q      <= reg_d;
      in_q       <= in_d;
      last_cpu_q <= last_cpu_d;
      last_dbg_q <= last_dbg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_dbg_d  = sel_dbg_q;
    rw_d       = rw_q;
    reg_d      = reg_q;
    in_d       = in_q;
    last_cpu_d = last_cpu_q;
    last_dbg_d = last_dbg_q;
    case (state_q)
      GRANT: state_d = RESP;
      default: begin
        if (cpu_ok || dbg_req) begin
          state_d    = GRANT;
          sel_dbg_d  = win_dbg;
          rw_d       = win_dbg ? dbg_rw    : cpu_rw;
          reg_d      = win_dbg ? dbg_reg   : cpu_reg;
          in_d       = win_dbg ? dbg_wdata : cpu_wdata;
          last_cpu_d = !win_dbg;
          last_dbg_d = win_dbg;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Strobes decode straight from state_q so an async reset kills rf_rw immediately.
  assign cpu_gnt    = (state_q == GRANT) && !sel_dbg_q;
  assign dbg_gnt    = (state_q == GRANT) &&  sel_dbg_q;
  assign rf_rw      = (state_q == GRANT) &&  rw_q;
  assign cpu_rvalid = (state_q == RESP)  && !rw_q && !sel_dbg_q;
  assign dbg_rvalid = (state_q == RESP)  && !rw_q &&  sel_dbg_q;
  assign rf_regname = reg_q;
  assign rf_in      = in_q;
  assign rdata      = rf_out;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a behavioural 16x8 register file.
// Build with REGFILE_ARB_LOCK_EN defined to also exercise the dbg_lock path.
module tb_regfile_port_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_rw = 1'b0, dbg_req = 1'b0, dbg_rw = 1'b0;
  logic [3:0] cpu_reg = '0, dbg_reg = '0;
  logic [7:0] cpu_wdata = '0, dbg_wdata = '0;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [7:0] rdata, rf_in;
  logic [3:0] rf_regname;
  logic       rf_rw;
  logic [7:0] rf_out = '0;
`ifdef REGFILE_ARB_LOCK_EN
  logic       dbg_lock = 1'b0;
`endif

  logic [7:0] rf_mem [16] = '{default: 8'h00};
  logic [7:0] model  [16] = '{default: 8'h00};

  typedef struct {bit who; bit rw; logic [3:0] r; logic [7:0] d;} gnt_t;
  typedef struct {bit who; logic [7:0] d;} rd_t;
  gnt_t gnt_q[$];
  rd_t  rd_q[$];

  int checks = 0;
  int errors = 0;

  regfile_port_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_reg(dbg_reg), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
`ifdef REGFILE_ARB_LOCK_EN
    .dbg_lock(dbg_lock),
`endif
    .rdata(rdata), .rf_regname(rf_regname), .rf_rw(rf_rw), .rf_in(rf_in), .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  // Register file: write on rf_rw, read data registered one cycle after the index.
  always @(posedge clk) begin
    if (rf_rw) rf_mem[rf_regname] <= rf_in;
    rf_out <= rf_mem[rf_regname];
  end

  // Scoreboard monitor: pops expectations whenever the DUT grants or returns data.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((cpu_gnt && dbg_gnt) || (cpu_rvalid && dbg_rvalid)) begin
        errors++;
        $display("FAIL exclusive gnt=%b%b rvalid=%b%b required at most one each",
                 cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid);
      end
      if (cpu_gnt || dbg_gnt) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_gnt cpu=%b dbg=%b required none", cpu_gnt, dbg_gnt);
        end else begin
          gnt_t g;
          g = gnt_q.pop_front();
          if ({dbg_gnt, rf_rw, rf_regname, (g.rw ? rf_in : g.d)} !== {g.who, g.rw, g.r, g.d}) begin
            errors++;
            $display("FAIL grant_cmd got who=%b rw=%b reg=%0d in=%h required who=%b rw=%b reg=%0d in=%h",
                     dbg_gnt, rf_rw, rf_regname, rf_in, g.who, g.rw, g.r, g.d);
          end
        end
      end
      if (cpu_rvalid || dbg_rvalid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid cpu=%b dbg=%b required none", cpu_rvalid, dbg_rvalid);
        end else begin
          rd_t e;
          e = rd_q.pop_front();
          if ({dbg_rvalid, rdata} !== {e.who, e.d}) begin
            errors++;
            $display("FAIL read_data got who=%b rdata=%h required who=%b rdata=%h",
                     dbg_rvalid, rdata, e.who, e.d);
          end
        end
      end
    end
  end

  task automatic expect_acc(input bit who, input bit rw, input logic [3:0] r, input logic [7:0] d);
    gnt_t g;
    rd_t  e;
    g = '{who, rw, r, (rw ? d : 8'h00)};
    gnt_q.push_back(g);
    if (rw) model[r] = d;
    else begin
      e = '{who, model[r]};
      rd_q.push_back(e);
    end
  endtask

  task automatic set_cpu(input bit req, input bit rw, input logic [3:0] r, input logic [7:0] d);
    cpu_req = req; cpu_rw = rw; cpu_reg = r; cpu_wdata = d;
  endtask

  task automatic set_dbg(input bit req, input bit rw, input logic [3:0] r, input logic [7:0] d);
    dbg_req = req; dbg_rw = rw; dbg_reg = r; dbg_wdata = d;
  endtask

  task automatic wait_gnt(input bit who, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(who ? dbg_gnt : cpu_gnt) && n < 16);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    set_cpu(1, 1, 4'd0, 8'hC3);
    set_dbg(1, 1, 4'd0, 8'h3C);
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, rf_rw} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b required 00000", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, rf_rw});
    end
    checks++;
    if ({rf_regname, rf_in} !== 12'h000) begin
      errors++;
      $display("FAIL reset_rf got reg=%0d in=%h required 0/00", rf_regname, rf_in);
    end
    expect_acc(0, 1, 4'd0, 8'hC3);
    expect_acc(1, 1, 4'd0, 8'h3C);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL first_tie got cpu=%b dbg=%b required cpu=1 dbg=0", cpu_gnt, dbg_gnt);
    end
    cpu_req = 1'b0;
    wait_gnt(1, n);
    dbg_req = 1'b0;
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL pending_dbg_gap got %0d required 2", n);
    end
    @(negedge clk);
  endtask

  task automatic test_cpu_rw();
    int n;
    expect_acc(0, 1, 4'd3, 8'h5A);
    set_cpu(1, 1, 4'd3, 8'h5A);
    wait_gnt(0, n);
    cpu_req = 1'b0;
    checks++;
    if (n != 1 || {rf_rw, rf_regname, rf_in} !== {1'b1, 4'd3, 8'h5A}) begin
      errors++;
      $display("FAIL cpu_write got lat=%0d rw=%b reg=%0d in=%h required lat=1 rw=1 reg=3 in=5a",
               n, rf_rw, rf_regname, rf_in);
    end
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, rf_rw} !== 2'b00) begin
      errors++;
      $display("FAIL write_resp got rvalid=%b rf_rw=%b required 0/0", cpu_rvalid, rf_rw);
    end
    expect_acc(0, 0, 4'd3, 8'h00);
    set_cpu(1, 0, 4'd3, 8'h00);
    wait_gnt(0, n);
    cpu_req = 1'b0;
    checks++;
    if (n != 1 || rf_rw !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_gnt got lat=%0d rf_rw=%b required lat=1 rf_rw=0", n, rf_rw);
    end
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL cpu_read_latency got rvalid=%b rdata=%h required 1/5a", cpu_rvalid, rdata);
    end
  endtask

  task automatic test_ordering();
    bit got_d, got_c, order_ok;
    int n;
    got_d = 0; got_c = 0; order_ok = 1; n = 0;
    expect_acc(1, 1, 4'd5, 8'h11);
    expect_acc(0, 0, 4'd5, 8'h00);
    set_dbg(1, 1, 4'd5, 8'h11);
    set_cpu(1, 0, 4'd5, 8'h00);
    while (!(got_d && got_c) && n < 16) begin
      @(negedge clk);
      n++;
      if (dbg_gnt) begin got_d = 1; dbg_req = 1'b0; end
      if (cpu_gnt) begin
        if (!got_d) order_ok = 0;
        got_c = 1; cpu_req = 1'b0;
      end
    end
    checks++;
    if (!(order_ok && got_d && got_c)) begin
      errors++;
      $display("FAIL order got dbg_first=%b both=%b required 1/1", order_ok, got_d && got_c);
    end
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, rdata} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL read_after_write got rvalid=%b rdata=%h required 1/11", cpu_rvalid, rdata);
    end
  endtask

  task automatic test_reset_midop();
    gnt_t g;
    int n;
    g = '{1'b1, 1'b1, 4'd2, 8'hFF};
    gnt_q.push_back(g);
    set_dbg(1, 1, 4'd2, 8'hFF);
    wait_gnt(1, n);
    dbg_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_rw, dbg_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL async_abort got rf_rw=%b gnt=%b required 0/0", rf_rw, dbg_gnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, rf_rw} !== 3'b000) begin
      errors++;
      $display("FAIL restart_idle got %b required 000", {cpu_gnt, dbg_gnt, rf_rw});
    end
    expect_acc(1, 0, 4'd2, 8'h00);
    set_dbg(1, 0, 4'd2, 8'h00);
    wait_gnt(1, n);
    dbg_req = 1'b0;
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL post_reset_lat got %0d required 1", n);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int g, cyc, last;
    g = 0; cyc = 0; last = 0;
    for (int i = 0; i < 4; i++) begin
      expect_acc(0, 0, 4'd3, 8'h00);
      expect_acc(1, 0, 4'd5, 8'h00);
    end
    set_cpu(1, 0, 4'd3, 8'h00);
    set_dbg(1, 0, 4'd5, 8'h00);
    while (g < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cpu_gnt || dbg_gnt) begin
        g++;
        checks++;
        if (dbg_gnt !== (g % 2 == 0) || (g > 1 && cyc - last != 2)) begin
          errors++;
          $display("FAIL alternation grant %0d got dbg=%b gap=%0d required dbg=%b gap=2",
                   g, dbg_gnt, cyc - last, (g % 2 == 0));
        end
        last = cyc;
      end
    end
    set_cpu(0, 0, 4'd0, 8'h00);
    set_dbg(0, 0, 4'd0, 8'h00);
    checks++;
    if (g != 8) begin
      errors++;
      $display("FAIL contention_count got %0d required 8", g);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef REGFILE_ARB_LOCK_EN
  task automatic test_lock();
    int n;
    bit leaked;
    leaked = 0;
    dbg_lock = 1'b1;
    expect_acc(1, 0, 4'd1, 8'h00);
    set_dbg(1, 0, 4'd1, 8'h00);
    wait_gnt(1, n);
    expect_acc(1, 1, 4'd1, 8'h99);
    expect_acc(0, 1, 4'd1, 8'h77);
    set_dbg(1, 1, 4'd1, 8'h99);
    set_cpu(1, 1, 4'd1, 8'h77);
    wait_gnt(1, n);
    dbg_req = 1'b0;
    checks++;
    if (n != 2 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_rmw got lat=%0d cpu_gnt=%b required 2/0", n, cpu_gnt);
    end
    repeat (6) begin
      @(negedge clk);
      if (cpu_gnt) leaked = 1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL lock_hold got cpu_gnt=1 required 0");
    end
    dbg_lock = 1'b0;
    wait_gnt(0, n);
    cpu_req = 1'b0;
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL lock_release got %0d required 1", n);
    end
    @(negedge clk);
    expect_acc(1, 0, 4'd1, 8'h00);
    set_dbg(1, 0, 4'd1, 8'h00);
    wait_gnt(1, n);
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_rw();
    test_ordering();
    test_reset_midop();
    test_back_to_back();
`ifdef REGFILE_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (gnt_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain got gnt_left=%0d rd_left=%0d required 0/0", gnt_q.size(), rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
